romc_arbiter: RTL and testbench

- Shares the dual-port 8x64 ROM (romc: clk, addr1/addr2 in, dout1/dout2 out, registered read) between NUM_REQ independent read clients.
- Each cycle, a round-robin scheduler grants up to two requests, one per ROM port.
- Granted addresses are registered onto the ROM ports.
- A tag pipeline routes each returning word to the requester that issued it.

---
 rtl/romc_arbiter.sv | 141 ++++++++++++++
 tb/tb_romc_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/romc_arbiter.sv
// Round-robin arbiter sharing a dual-port registered-read ROM between NUM_REQ clients.
// Optional ROMC_ARB_MERGE_EN: same-address requests piggyback on the port-1 read.
module romc_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 64,
  parameter int ROM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0]   rsp_data,
  output logic [ADDR_W-1:0]           rom_addr1,
  output logic [ADDR_W-1:0]           rom_addr2,
  input  logic [DATA_W-1:0]           rom_dout1,
  input  logic [DATA_W-1:0]           rom_dout2
);

  localparam int PTR_W = $clog2(NUM_REQ);
  typedef logic [PTR_W-1:0] idx_t;

`ifdef ROMC_ARB_MERGE_EN
  localparam int TAG_W = NUM_REQ;
`else
  localparam int TAG_W = PTR_W + 1;
`endif

  // Explicit wrap so non-power-of-two NUM_REQ never indexes past the last client.
  function automatic idx_t wrap_add(idx_t base, int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return idx_t'(s);
  endfunction

  idx_t                ptr, ptr_next, win1, win2, cand;
  logic                found1, found2;
  logic [NUM_REQ-1:0]  mask1, mask2, hit1, hit2;
  logic [ADDR_W-1:0]   addr1_sel, addr2_sel;
  logic [TAG_W-1:0]    tag1_new, tag2_new;
  logic [TAG_W-1:0]    tag1_q [0:ROM_LAT];
  logic [TAG_W-1:0]    tag2_q [0:ROM_LAT];

  always_comb begin
    found1    = 1'b0;
    found2    = 1'b0;
    win1      = '0;
    win2      = '0;
    cand      = '0;
    mask1     = '0;
    mask2     = '0;
    addr1_sel = '0;
    addr2_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(ptr, k);
      if (req[cand]) begin
        if (!found1) begin
          found1      = 1'b1;
          win1        = cand;
          addr1_sel   = req_addr[cand*ADDR_W +: ADDR_W];
          mask1[cand] = 1'b1;
        end
`ifdef ROMC_ARB_MERGE_EN
        else if (req_addr[cand*ADDR_W +: ADDR_W] == addr1_sel) begin
          mask1[cand] = 1'b1;
        end
`endif
        else if (!found2) begin
          found2      = 1'b1;
          win2        = cand;
          addr2_sel   = req_addr[cand*ADDR_W +: ADDR_W];
          mask2[cand] = 1'b1;
        end
      end
    end
    if (found2)      ptr_next = wrap_add(win2, 1);
    else if (found1) ptr_next = wrap_add(win1, 1);
    else             ptr_next = ptr;
  end

  assign gnt = rst ? '0 : (mask1 | mask2);

  // Tag encoding: requester mask when merging, {valid, index} otherwise.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
`ifdef ROMC_ARB_MERGE_EN
    tag1_new = mask1;
    tag2_new = mask2;
    hit1     = tag1_q[ROM_LAT];
    hit2     = tag2_q[ROM_LAT];
`else
    tag1_new = {found1, win1};
    tag2_new = {found2, win2};
    for (int i = 0; i < NUM_REQ; i++) begin
      hit1[i] = tag1_q[ROM_LAT][PTR_W] && (tag1_q[ROM_LAT][PTR_W-1:0] == idx_t'(i));
      hit2[i] = tag2_q[ROM_LAT][PTR_W] && (tag2_q[ROM_LAT][PTR_W-1:0] == idx_t'(i));
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      rom_addr1 <= '0;
      rom_addr2 <= '0;
      for (int s = 0; s <= ROM_LAT; s++) begin
        tag1_q[s] <= '0;
        tag2_q[s] <= '0;
      end
    end else begin
      ptr <= ptr_next;
      if (found1) rom_addr1 <= addr1_sel;
      if (found2) rom_addr2 <= addr2_sel;
      tag1_q[0] <= tag1_new;
      tag2_q[0] <= tag2_new;
      for (int s = 1; s <= ROM_LAT; s++) begin
        tag1_q[s] <= tag1_q[s-1];
        tag2_q[s] <= tag2_q[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hit1[i]) begin
        rsp_valid[i]                   = 1'b1;
        rsp_data[i*DATA_W +: DATA_W]   = rom_dout1;
      end else if (hit2[i]) begin
        rsp_valid[i]                   = 1'b1;
        rsp_data[i*DATA_W +: DATA_W]   = rom_dout2;
      end
    end
  end

endmodule

// File: tb/tb_romc_arbiter.sv
// Bench for romc_arbiter: ROM model plus a time-indexed response scoreboard.
// Build with +define+ROMC_ARB_MERGE_EN to exercise the merge variant.
module tb_romc_arbiter;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 64;

  typedef logic [N-1:0]    req_t;
  typedef logic [N*AW-1:0] avec_t;
  typedef logic [AW-1:0]   addr_t;

  logic          clk = 1'b0;
  logic          rst;
  req_t          req;
  avec_t         req_addr;
  req_t          gnt, rsp_valid;
  logic [N*DW-1:0] rsp_data;
  addr_t         rom_addr1, rom_addr2;
  logic [DW-1:0] rom_dout1, rom_dout2;

  always #5 clk = ~clk;

  romc_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rom_addr1(rom_addr1),
    .rom_addr2(rom_addr2), .rom_dout1(rom_dout1), .rom_dout2(rom_dout2)
  );

  logic [DW-1:0] rom_mem [0:7];
  always @(posedge clk) begin
    rom_dout1 <= rom_mem[rom_addr1];
    rom_dout2 <= rom_mem[rom_addr2];
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: grants from the scan rule, responses booked two cycles ahead.
  int            m_ptr, m_n, m_w1, m_w2;
  addr_t         m_a1, m_a2, m_addr1, m_addr2;
  req_t          m_mask1, m_mask2, m_gnt;
  req_t          sched_v [0:7];
  logic [DW-1:0] sched_d [0:7][0:N-1];

  function automatic addr_t addr_of(int i);
    return req_addr[i*AW +: AW];
  endfunction

  function automatic logic [N*DW-1:0] exp_data();
    logic [N*DW-1:0] v;
    int s;
    v = '0;
    s = cyc % 8;
    for (int i = 0; i < N; i++)
      if (sched_v[s][i]) v[i*DW +: DW] = sched_d[s][i];
    return v;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_n = 0; m_addr1 = '0; m_addr2 = '0;
    m_mask1 = '0; m_mask2 = '0; m_gnt = '0;
    for (int s = 0; s < 8; s++) sched_v[s] = '0;
  endtask

  task automatic model_arb();
    int idx;
    m_mask1 = '0; m_mask2 = '0; m_n = 0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (req[idx]) begin
          if (m_n == 0) begin
            m_n = 1; m_w1 = idx; m_a1 = addr_of(idx); m_mask1[idx] = 1'b1;
          end
`ifdef ROMC_ARB_MERGE_EN
          else if (addr_of(idx) == m_a1) m_mask1[idx] = 1'b1;
`endif
          else if (m_n == 1) begin
            m_n = 2; m_w2 = idx; m_a2 = addr_of(idx); m_mask2[idx] = 1'b1;
          end
        end
      end
    end
    m_gnt = m_mask1 | m_mask2;
  endtask

  task automatic model_commit();
    int s;
    s = (cyc + 2) % 8;
    if (m_n >= 1) begin
      m_addr1 = m_a1;
      for (int i = 0; i < N; i++)
        if (m_mask1[i]) begin sched_v[s][i] = 1'b1; sched_d[s][i] = rom_mem[m_a1]; end
    end
    if (m_n == 2) begin
      m_addr2 = m_a2;
      for (int i = 0; i < N; i++)
        if (m_mask2[i]) begin sched_v[s][i] = 1'b1; sched_d[s][i] = rom_mem[m_a2]; end
    end
    if (m_n == 2)      m_ptr = (m_w2 + 1) % N;
    else if (m_n == 1) m_ptr = (m_w1 + 1) % N;
    sched_v[cyc % 8] = '0;
  endtask

  task automatic drive(input logic r, input req_t q, input avec_t a);
    @(posedge clk);
    model_commit();
    cyc++;
    #1;
    rst = r; req = q; req_addr = a;
    if (r) model_reset();
    model_arb();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, req_t'($urandom), avec_t'($urandom));
      @(negedge clk);
      n_cmp++;
      if ({gnt, rsp_valid, rom_addr1, rom_addr2} !== {m_gnt, sched_v[cyc%8], m_addr1, m_addr2}) begin
        n_fail++;
        $display("[TB] FAIL reset ctl cyc=%0d got gnt=%b v=%b a1=%0d a2=%0d exp gnt=%b v=%b a1=%0d a2=%0d",
                 cyc, gnt, rsp_valid, rom_addr1, rom_addr2, m_gnt, sched_v[cyc%8], m_addr1, m_addr2);
      end
      n_cmp++;
      if (rsp_data !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset data cyc=%0d got=%h exp=0", cyc, rsp_data);
      end
    end
  endtask

  task automatic test_single();
    req_t q [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, q[c], {3'd1, 3'd6, 3'd2, 3'd5});
      @(negedge clk);
      n_cmp++;
      if ({gnt, rsp_valid, rom_addr1, rom_addr2} !== {m_gnt, sched_v[cyc%8], m_addr1, m_addr2}) begin
        n_fail++;
        $display("[TB] FAIL single ctl cyc=%0d got gnt=%b v=%b a1=%0d a2=%0d exp gnt=%b v=%b a1=%0d a2=%0d",
                 cyc, gnt, rsp_valid, rom_addr1, rom_addr2, m_gnt, sched_v[cyc%8], m_addr1, m_addr2);
      end
      n_cmp++;
      if (rsp_data !== exp_data()) begin
        n_fail++;
        $display("[TB] FAIL single data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_data());
      end
      if (c == 3) begin
        n_cmp++;
        if (rom_addr1 !== 3'd5) begin
          n_fail++;
          $display("[TB] FAIL single rom_addr1 got=%0d exp=5", rom_addr1);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if ({rsp_valid, rsp_data[DW-1:0]} !== {4'b0001, rom_mem[5]}) begin
          n_fail++;
          $display("[TB] FAIL single rsp got v=%b d=%h exp v=0001 d=%h", rsp_valid, rsp_data[DW-1:0], rom_mem[5]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, (c < 8) ? 4'b1111 : 4'b0000, {3'd4, 3'd2, 3'd7, 3'd0});
      @(negedge clk);
      n_cmp++;
      if ({gnt, rsp_valid, rom_addr1, rom_addr2} !== {m_gnt, sched_v[cyc%8], m_addr1, m_addr2}) begin
        n_fail++;
        $display("[TB] FAIL b2b ctl cyc=%0d got gnt=%b v=%b a1=%0d a2=%0d exp gnt=%b v=%b a1=%0d a2=%0d",
                 cyc, gnt, rsp_valid, rom_addr1, rom_addr2, m_gnt, sched_v[cyc%8], m_addr1, m_addr2);
      end
      n_cmp++;
      if (rsp_data !== exp_data()) begin
        n_fail++;
        $display("[TB] FAIL b2b data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_data());
      end
    end
  endtask

  task automatic test_wrap();
    req_t q [5] = '{4'b0100, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, q[c], {3'd6, 3'd1, 3'd3, 3'd2});
      @(negedge clk);
      n_cmp++;
      if ({gnt, rsp_valid, rom_addr1, rom_addr2} !== {m_gnt, sched_v[cyc%8], m_addr1, m_addr2}) begin
        n_fail++;
        $display("[TB] FAIL wrap ctl cyc=%0d got gnt=%b v=%b a1=%0d a2=%0d exp gnt=%b v=%b a1=%0d a2=%0d",
                 cyc, gnt, rsp_valid, rom_addr1, rom_addr2, m_gnt, sched_v[cyc%8], m_addr1, m_addr2);
      end
      n_cmp++;
      if (rsp_data !== exp_data()) begin
        n_fail++;
        $display("[TB] FAIL wrap data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_data());
      end
      if (c == 2) begin
        n_cmp++;
        if ({rom_addr1, rom_addr2} !== {3'd6, 3'd2}) begin
          n_fail++;
          $display("[TB] FAIL wrap ports got a1=%0d a2=%0d exp a1=6 a2=2", rom_addr1, rom_addr2);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic r_seq [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    req_t q [7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    for (int c = 0; c < 7; c++) begin
      drive(r_seq[c], q[c], {3'd4, 3'd3, 3'd2, 3'd1});
      if (c == 1) begin
        #1;
        n_cmp++;
        if ({gnt, rsp_valid, rom_addr1, rom_addr2} !== '0) begin
          n_fail++;
          $display("[TB] FAIL midreset immediate got gnt=%b v=%b a1=%0d a2=%0d exp all 0",
                   gnt, rsp_valid, rom_addr1, rom_addr2);
        end
      end
      @(negedge clk);
      n_cmp++;
      if ({gnt, rsp_valid, rom_addr1, rom_addr2} !== {m_gnt, sched_v[cyc%8], m_addr1, m_addr2}) begin
        n_fail++;
        $display("[TB] FAIL midreset ctl cyc=%0d got gnt=%b v=%b a1=%0d a2=%0d exp gnt=%b v=%b a1=%0d a2=%0d",
                 cyc, gnt, rsp_valid, rom_addr1, rom_addr2, m_gnt, sched_v[cyc%8], m_addr1, m_addr2);
      end
      n_cmp++;
      if (rsp_data !== exp_data()) begin
        n_fail++;
        $display("[TB] FAIL midreset data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_data());
      end
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, (c < 3) ? req_t'($urandom) : 4'b0000, avec_t'($urandom));
      @(negedge clk);
      n_cmp++;
      if ({gnt, rsp_valid, rom_addr1, rom_addr2} !== {m_gnt, sched_v[cyc%8], m_addr1, m_addr2}) begin
        n_fail++;
        $display("[TB] FAIL idle ctl cyc=%0d got gnt=%b v=%b a1=%0d a2=%0d exp gnt=%b v=%b a1=%0d a2=%0d",
                 cyc, gnt, rsp_valid, rom_addr1, rom_addr2, m_gnt, sched_v[cyc%8], m_addr1, m_addr2);
      end
      n_cmp++;
      if (rsp_data !== exp_data()) begin
        n_fail++;
        $display("[TB] FAIL idle data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_data());
      end
    end
  endtask

  task automatic test_random();
    req_t  pend;
    addr_t paddr [N];
    req_t  q;
    avec_t a;
    pend = '0;
    for (int i = 0; i < N; i++) paddr[i] = '0;
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            pend[i]  = 1'b1;
            paddr[i] = addr_t'($urandom_range(0, 7));
          end
        end else if ($urandom_range(0, 9) == 0) begin
          pend[i] = 1'b0;
        end
      end
      q = (c < 76) ? pend : 4'b0000;
      for (int i = 0; i < N; i++) a[i*AW +: AW] = paddr[i];
      drive(1'b0, q, a);
      @(negedge clk);
      n_cmp++;
      if ({gnt, rsp_valid, rom_addr1, rom_addr2} !== {m_gnt, sched_v[cyc%8], m_addr1, m_addr2}) begin
        n_fail++;
        $display("[TB] FAIL random ctl cyc=%0d got gnt=%b v=%b a1=%0d a2=%0d exp gnt=%b v=%b a1=%0d a2=%0d",
                 cyc, gnt, rsp_valid, rom_addr1, rom_addr2, m_gnt, sched_v[cyc%8], m_addr1, m_addr2);
      end
      n_cmp++;
      if (rsp_data !== exp_data()) begin
        n_fail++;
        $display("[TB] FAIL random data cyc=%0d got=%h exp=%h", cyc, rsp_data, exp_data());
      end
      pend = pend & ~m_gnt;
    end
  endtask

`ifdef ROMC_ARB_MERGE_EN
  task automatic test_merge();
    logic r_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    req_t q [5] = '{4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000};
    for (int c = 0; c < 5; c++) begin
      drive(r_seq[c], q[c], {3'd0, 3'd6, 3'd3, 3'd3});
      @(negedge clk);
      n_cmp++;
      if ({gnt, rsp_valid, rom_addr1, rom_addr2} !== {m_gnt, sched_v[cyc%8], m_addr1, m_addr2}) begin
        n_fail++;
        $display("[TB] FAIL merge ctl cyc=%0d got gnt=%b v=%b a1=%0d a2=%0d exp gnt=%b v=%b a1=%0d a2=%0d",
                 cyc, gnt, rsp_valid, rom_addr1, rom_addr2, m_gnt, sched_v[cyc%8], m_addr1, m_addr2);
      end
      if (c == 1) begin
        n_cmp++;
        if (gnt !== 4'b0111) begin
          n_fail++;
          $display("[TB] FAIL merge gnt got=%b exp=0111", gnt);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if ({rsp_valid, rsp_data[3*DW-1:0]} !== {4'b0111, rom_mem[6], rom_mem[3], rom_mem[3]}) begin
          n_fail++;
          $display("[TB] FAIL merge rsp got v=%b d=%h exp v=0111", rsp_valid, rsp_data[3*DW-1:0]);
        end
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = '0;
    req_addr = '0;
    for (int i = 0; i < 8; i++) rom_mem[i] = {$urandom, $urandom};
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_reset_midflight();
    test_idle();
    test_random();
`ifdef ROMC_ARB_MERGE_EN
    test_merge();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
